// File: rtl/lut_neuron_array_rt_if.sv
// Streaming vector channels (input addresses, output results) for lut_neuron_array_rt.
interface lut_neuron_array_rt_if #(
    parameter int NUM_NEURONS = 4,
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 1
);
    // A beat moves on a rising edge with valid & ready both high; a held valid keeps its data stable.
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/lut_neuron_array_rt.sv
// Array of runtime-loadable LUT neurons as a valid/ready streaming layer.
// Optional table readback port enabled by defining LUT_NEURON_READBACK_EN.
module lut_neuron_array_rt #(
    parameter int   NUM_NEURONS = 4,
    parameter int   IN_BITS     = 8,
    parameter int   OUT_BITS    = 1,
    parameter int   PIPE_STAGES = 1,
    localparam int  NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_neuron_array_rt_if.slave io,
    input  logic                 cfg_start,
    input  logic [NW-1:0]        cfg_neuron,
    input  logic                 cfg_wvalid,
    output logic                 cfg_wready,
    input  logic [OUT_BITS-1:0]  cfg_wdata,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy,
    output logic [1:0]           state_o
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic [NW-1:0]        rb_neuron,
    input  logic [IN_BITS-1:0]   rb_addr,
    output logic [OUT_BITS-1:0]  rb_data
`endif
);
    localparam int               DEPTH = 2**IN_BITS;
    localparam int               IW    = NUM_NEURONS*IN_BITS;
    localparam int               OW    = NUM_NEURONS*OUT_BITS;
    localparam logic [IN_BITS:0] LAST  = (IN_BITS+1)'(DEPTH-1);
    localparam logic [NW:0]      NUM_N = (NW+1)'(NUM_NEURONS);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_LOAD = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [NW-1:0]    idx_q, idx_d;
    logic [IN_BITS:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [OUT_BITS-1:0] table_q [NUM_NEURONS][DEPTH];

    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] lk_addr;
    logic [OW-1:0] lk_data;
    logic          lk_valid;
    logic          out_adv, pipe_empty, in_fire, wr_fire;

    assign out_adv    = !out_valid_q || io.out_ready;
    assign in_fire    = io.in_valid && io.in_ready;
    assign wr_fire    = (state_q == ST_LOAD) && cfg_wvalid;
    assign cfg_wready = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_RUN);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign state_o    = state_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

    if (PIPE_STAGES == 2) begin : g_pipe2
        logic          s1_valid_q;
        logic [IW-1:0] s1_addr_q;
        logic          s1_adv;

        // Stage 1 only moves when it is empty or the output stage is taking its vector.
        assign s1_adv      = !s1_valid_q || out_adv;
        assign io.in_ready = (state_q == ST_RUN) && s1_adv;
        assign lk_valid    = s1_valid_q;
        assign lk_addr     = s1_addr_q;
        assign pipe_empty  = !out_valid_q && !s1_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_addr_q  <= '0;
            end else begin
                if (s1_adv) s1_valid_q <= in_fire;
                if (in_fire) s1_addr_q <= io.in_data;
            end
        end
    end else begin : g_pipe1
        assign io.in_ready = (state_q == ST_RUN) && out_adv;
        assign lk_valid    = in_fire;
        assign lk_addr     = io.in_data;
        assign pipe_empty  = !out_valid_q;
    end

    always_comb begin
        lk_data = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            lk_data[n*OUT_BITS +: OUT_BITS] = table_q[n][lk_addr[n*IN_BITS +: IN_BITS]];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_adv) begin
            out_valid_d = lk_valid;
            if (lk_valid) out_data_d = lk_data;
        end
    end

    // Table RAM is deliberately unreset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_fire) table_q[idx_q][cnt_q[IN_BITS-1:0]] <= cfg_wdata;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_start) begin
                    if ({1'b0, cfg_neuron} < NUM_N) begin
                        idx_d   = cfg_neuron;
                        state_d = ST_DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (wr_fire) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef LUT_NEURON_READBACK_EN
    logic [OUT_BITS-1:0] rb_q, rb_d;

    always_comb begin
        rb_d = '0;
        if ({1'b0, rb_neuron} < NUM_N) rb_d = table_q[rb_neuron][rb_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rb_q <= '0;
        else        rb_q <= rb_d;
    end

    assign rb_data = rb_q;
`endif
endmodule
